single_port_ram_be: RTL and testbench

Parametrised successor to the team's 8x256 single-port RAM. Adds:
- configurable data width and depth
- per-byte write enables
- selectable read-during-write mode
- optional output pipeline register
- a hardware clear sequencer, so contents are deterministic after reset

Used as the general scratch/buffer memory in datapath blocks.

---
 rtl/single_port_ram_be.sv | 237 +++++++++++++++++++++++
 tb/tb_single_port_ram_be.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_port_ram_be.sv
// Parameterised single-port RAM with per-byte write enables, selectable
// read-during-write behaviour, an optional output pipeline stage and a
// hardware clear sweep that zeroes the array after reset or on request.
// Optional feature macro: SINGLE_PORT_RAM_BE_PARITY_EN. It adds per-byte
// even parity storage, the par_err output and the inj_err input.
module single_port_ram_be #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic                clr,
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
  input  logic                inj_err,
  output logic [DATA_W/8-1:0] par_err,
`endif
  output logic [DATA_W-1:0]   dout,
  output logic                rd_valid,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic                busy_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                acc_s;
  logic                rd_req_s;
  logic                wr_req_s;
  logic [DATA_W-1:0]   old_s;
  logic [DATA_W-1:0]   merged_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  logic [DATA_W-1:0]   dout1_r;
  logic                valid1_r;

  // Qualify user accesses (clr and the sweep win) and build the byte-merged write word
  always_comb begin
    old_s    = mem_r[addr];
    merged_s = old_s;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        merged_s[8*i +: 8] = din[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = old_s[8*i +: 8];
      end
    end
    acc_s    = (state_r == ST_IDLE) && en && !clr;
    rd_req_s = acc_s && !we;
    wr_req_s = acc_s && we;
    if (state_r == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = ptr_r;
      mem_wdata_s = {DATA_W{1'b0}};
    end else if (wr_req_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = addr;
      mem_wdata_s = merged_s;
    end else begin
      mem_we_s    = 1'b0;
      mem_waddr_s = addr;
      mem_wdata_s = merged_s;
    end
  end

  // Clear sequencer: sweep zeros over every word, then serve user accesses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      ptr_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (ptr_r == PTR_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            ptr_r <= ptr_r + ADDR_W'(1'b1);
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state_r <= ST_CLEAR;
            ptr_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          ptr_r   <= {ADDR_W{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Storage array; contents are deliberately not reset, the sweep zeroes them
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // First output stage: read data, or the read-during-write value chosen by RD_MODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout1_r  <= {DATA_W{1'b0}};
      valid1_r <= 1'b0;
    end else begin
      valid1_r <= rd_req_s;
      if (rd_req_s) begin
        dout1_r <= old_s;
      end else if (wr_req_s) begin
        case (RD_MODE)
          32'sd0:  dout1_r <= old_s;
          32'sd1:  dout1_r <= merged_s;
          default: dout1_r <= dout1_r;
        endcase
      end
    end
  end

`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
  // Even parity of every byte of a word
  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    p = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      p[i] = ^w[8*i +: 8];
    end
    return p;
  endfunction

  logic [NB-1:0] par_mem_r [DEPTH];
  logic [NB-1:0] par_old_s;
  logic [NB-1:0] par_new_s;
  logic [NB-1:0] par_wdata_s;
  logic [NB-1:0] perr1_r;

  // Parity of the merged word; enabled bytes may be deliberately corrupted
  always_comb begin
    par_old_s   = par_mem_r[addr];
    par_new_s   = byte_par(merged_s);
    par_wdata_s = par_old_s;
    if (state_r == ST_CLEAR) begin
      par_wdata_s = {NB{1'b0}};
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          par_wdata_s[i] = par_new_s[i] ^ inj_err;
        end else begin
          par_wdata_s[i] = par_old_s[i];
        end
      end
    end
  end

  // Parity storage follows the data array write for write
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      par_mem_r[mem_waddr_s] <= par_wdata_s;
    end
  end

  // Per-byte parity check on reads, aligned with the first output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr1_r <= {NB{1'b0}};
    end else if (rd_req_s) begin
      perr1_r <= par_old_s ^ byte_par(old_s);
    end else begin
      perr1_r <= {NB{1'b0}};
    end
  end
`endif

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] dout2_r;
      logic              valid2_r;
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
      logic [NB-1:0]     perr2_r;

      // Extra pipeline stage for the parity flags
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          perr2_r <= {NB{1'b0}};
        end else begin
          perr2_r <= perr1_r;
        end
      end
      assign par_err = perr2_r;
`endif

      // Extra pipeline stage for data and valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout2_r  <= {DATA_W{1'b0}};
          valid2_r <= 1'b0;
        end else begin
          dout2_r  <= dout1_r;
          valid2_r <= valid1_r;
        end
      end
      assign dout     = dout2_r;
      assign rd_valid = valid2_r;
    end else begin : g_no_out_reg
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
      assign par_err = perr1_r;
`endif
      assign dout     = dout1_r;
      assign rd_valid = valid1_r;
    end
  endgenerate

  assign busy = busy_r;

endmodule

// File: tb/tb_single_port_ram_be.sv
// Bench for single_port_ram_be: four instances (READ_FIRST, WRITE_FIRST,
// NO_CHANGE, and READ_FIRST with output register) share one stimulus stream
// and are compared every cycle against a word-level reference model.
module tb_single_port_ram_be;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          we;
  logic          clr;
  logic [NB-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
  logic          inj_err;
  logic [NB-1:0] par_err [4];
`endif
  logic [DW-1:0] dout [4];
  logic          rd_valid [4];
  logic          busy [4];

  // reference model state
  logic [DW-1:0] mem_m [DEPTH];
  logic [NB-1:0] par_m [DEPTH];
  int            busy_left;
  logic [DW-1:0] exp_dout [4];
  logic          exp_valid [4];
  logic [NB-1:0] exp_perr [4];

  int checks;
  int failures;

  always #5 clk = ~clk;

  single_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .OUT_REG(0)) u_rf (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
    .inj_err(inj_err), .par_err(par_err[0]),
`endif
    .dout(dout[0]), .rd_valid(rd_valid[0]), .busy(busy[0]));

  single_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .OUT_REG(0)) u_wf (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
    .inj_err(inj_err), .par_err(par_err[1]),
`endif
    .dout(dout[1]), .rd_valid(rd_valid[1]), .busy(busy[1]));

  single_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(2), .OUT_REG(0)) u_nc (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
    .inj_err(inj_err), .par_err(par_err[2]),
`endif
    .dout(dout[2]), .rd_valid(rd_valid[2]), .busy(busy[2]));

  single_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .OUT_REG(1)) u_pipe (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
    .inj_err(inj_err), .par_err(par_err[3]),
`endif
    .dout(dout[3]), .rd_valid(rd_valid[3]), .busy(busy[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NB-1:0] parity_of(input logic [DW-1:0] w);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
    return p;
  endfunction

  task automatic model_zero();
    for (int a = 0; a < DEPTH; a++) begin
      mem_m[a] = '0;
      par_m[a] = '0;
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("busy%0d", m), 32'(busy[m]), 32'(busy_left > 0));
      chk($sformatf("rd_valid%0d", m), 32'(rd_valid[m]), 32'(exp_valid[m]));
      chk($sformatf("dout%0d", m), 32'(dout[m]), 32'(exp_dout[m]));
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
      chk($sformatf("par_err%0d", m), 32'(par_err[m]), 32'(exp_perr[m]));
`endif
    end
  endtask

  // Called at a falling edge: asserts reset, checks reset values, releases it
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0; be = '0; addr = '0; din = '0;
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
    inj_err = 1'b0;
`endif
    #1;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_busy%0d", m), 32'(busy[m]), 32'd1);
      chk($sformatf("rst_valid%0d", m), 32'(rd_valid[m]), 32'd0);
      chk($sformatf("rst_dout%0d", m), 32'(dout[m]), 32'd0);
      exp_dout[m] = '0; exp_valid[m] = 1'b0; exp_perr[m] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    busy_left = DEPTH;
    model_zero();
  endtask

  // Called at a falling edge: drive one cycle, predict, check after the edge
  task automatic do_cycle(input logic c_en, input logic c_we, input logic [NB-1:0] c_be,
                          input logic [AW-1:0] c_addr, input logic [DW-1:0] c_din,
                          input logic c_clr, input logic c_inj);
    logic [DW-1:0] rv;
    logic [DW-1:0] nv;
    logic [NB-1:0] np;
    logic [DW-1:0] pd;
    logic          pv;
    logic [NB-1:0] pp;
    logic          acc;
    en = c_en; we = c_we; be = c_be; addr = c_addr; din = c_din; clr = c_clr;
`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
    inj_err = c_inj;
`endif
    pd = exp_dout[0]; pv = exp_valid[0]; pp = exp_perr[0];
    acc = (busy_left == 0) && c_en && !c_clr;
    for (int m = 0; m < 3; m++) begin
      exp_valid[m] = 1'b0;
      exp_perr[m]  = '0;
    end
    if (acc && !c_we) begin
      rv = mem_m[c_addr];
      for (int m = 0; m < 3; m++) begin
        exp_dout[m]  = rv;
        exp_valid[m] = 1'b1;
        exp_perr[m]  = par_m[c_addr] ^ parity_of(rv);
      end
    end else if (acc && c_we) begin
      rv = mem_m[c_addr];
      nv = rv;
      np = par_m[c_addr];
      for (int b = 0; b < NB; b++) begin
        if (c_be[b]) begin
          nv[8*b +: 8] = c_din[8*b +: 8];
          np[b] = (^c_din[8*b +: 8]) ^ c_inj;
        end
      end
      exp_dout[0] = rv;
      exp_dout[1] = nv;
      mem_m[c_addr] = nv;
      par_m[c_addr] = np;
    end
    exp_dout[3] = pd; exp_valid[3] = pv; exp_perr[3] = pp;
    if (busy_left > 0) busy_left--;
    else if (c_clr) begin
      busy_left = DEPTH;
      model_zero();
    end
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    do_cycle(1'b1, 1'b0, '0, a, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
    do_cycle(1'b1, 1'b1, b, a, d, 1'b0, 1'b0);
  endtask

  // noisy busy cycle: random access pulses and stray clr requests
  task automatic noisy();
    do_cycle(1'($urandom), 1'($urandom), NB'($urandom), AW'($urandom_range(0, 15)),
             DW'($urandom), 1'($urandom_range(0, 7) == 0), 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;

    // 1. reset, exact sweep length, reads of cleared words
    do_reset();
    for (int c = 0; c < DEPTH; c++) begin
      idle();
      if (c == DEPTH - 2) chk("t1_busy_last", 32'(busy[0]), 32'd1);
    end
    chk("t1_busy_done", 32'(busy[0]), 32'd0);
    rd(8'h00);
    chk("t1_rd00", 32'(dout[0]), 32'h0000);
    rd(8'h7F);
    rd(8'hFF);
    chk("t1_rdFF_valid", 32'(rd_valid[0]), 32'd1);
    idle();

    // 2. byte enables
    wr(8'h05, 16'hAAAA, 2'b11);
    wr(8'h05, 16'h1255, 2'b01);
    rd(8'h05);
    chk("t2_rd5", 32'(dout[0]), 32'hAA55);
    wr(8'h0A, 16'h5555, 2'b00);
    rd(8'h0A);
    chk("t2_rdA", 32'(dout[0]), 32'h0000);

    // 3. read during write in the three modes
    wr(8'h05, 16'h1234, 2'b11);
    chk("t3_read_first", 32'(dout[0]), 32'hAA55);
    chk("t3_write_first", 32'(dout[1]), 32'h1234);
    chk("t3_no_change", 32'(dout[2]), 32'h0000);
    chk("t3_no_valid", 32'(rd_valid[1]), 32'd0);

    // 4. pipelined back-to-back reads
    rd(8'h05);
    chk("t4_pipe_lat", 32'(rd_valid[3]), 32'd0);
    rd(8'h0A);
    chk("t4_pipe_d0", 32'(dout[3]), 32'h1234);
    rd(8'h05);
    chk("t4_pipe_d1", 32'(dout[3]), 32'h0000);
    idle();
    chk("t4_pipe_d2", 32'(dout[3]), 32'h1234);
    idle();
    chk("t4_pipe_end", 32'(rd_valid[3]), 32'd0);

    // 5. clear contention, accesses during busy, reset mid-sweep
    wr(8'h03, 16'hBEEF, 2'b11);
    do_cycle(1'b1, 1'b1, 2'b11, 8'h04, 16'h1111, 1'b1, 1'b0);
    chk("t5_clr_busy", 32'(busy[0]), 32'd1);
    for (int c = 0; c < DEPTH - 1; c++) noisy();
    rd(8'h03);
    chk("t5_rd3", 32'(dout[0]), 32'h0000);
    rd(8'h04);
    wr(8'h06, 16'hCAFE, 2'b11);
    do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 100; c++) noisy();
    do_reset();
    for (int c = 0; c < DEPTH; c++) noisy();
    rd(8'h06);
    chk("t5_rd6", 32'(dout[0]), 32'h0000);

`ifdef SINGLE_PORT_RAM_BE_PARITY_EN
    // 6. parity error injection
    do_cycle(1'b1, 1'b1, 2'b10, 8'h07, 16'hC3C3, 1'b0, 1'b1);
    rd(8'h07);
    chk("t6_perr_inj", 32'(par_err[0]), 32'h2);
    wr(8'h07, 16'hC3C3, 2'b11);
    rd(8'h07);
    chk("t6_perr_clean", 32'(par_err[0]), 32'h0);
`endif

    // randomized traffic, including occasional clears
    for (int c = 0; c < 800; c++) begin
      do_cycle(1'($urandom), 1'($urandom), NB'($urandom), AW'($urandom_range(0, 15)),
               DW'($urandom), 1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
